// File: rtl/micro_sequencer.sv
// Microprogram sequencer: five-phase cycle (T1/T3/T5), micro-PC and MIR load strobe; MICRO_BREAK_EN adds a UPC breakpoint freeze.
// Latency: UPC and the sequence latch update at the P4 edge (one branch delay slot); WAIT in P2 stretches T3, and a break holds P0 until UCONT.
module micro_sequencer #(
  parameter int UPCW = 12,
  parameter int STKD = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            MCL_n,
  input  logic [18:0]     ROM18_0,
  input  logic [15:0]     COND,
  input  logic [5:0]      IRDISP,
  input  logic            WAIT,
`ifdef MICRO_BREAK_EN
  input  logic [UPCW-1:0] BRKADR,
  input  logic            BRKENA,
  input  logic            UCONT,
  output logic            UBRK,
`endif
  output logic [UPCW-1:0] UPC,
  output logic            MIRKL,
  output logic            T1,
  output logic            T3,
  output logic            T5,
  output logic            ACTLOOP,
  output logic            STKERR
);

  localparam int SPW  = $clog2(STKD + 1);
  localparam int IDXW = $clog2(STKD);

  typedef enum logic [2:0] {P0, P1, P2, P3, P4} phase_e;
  typedef enum logic [2:0] {
    SQ_CONT, SQ_JMP, SQ_CJMP, SQ_CALL, SQ_RET, SQ_DISP, SQ_LDCNT, SQ_LOOP
  } sq_e;

  phase_e          phase_q, phase_d;
  logic [UPCW-1:0] upc_q, upc_d;
  sq_e             sq_q, sq_d;
  logic [3:0]      csel_q, csel_d;
  logic [11:0]     adr_q, adr_d;
  logic [UPCW-1:0] stk_q [STKD];
  logic [UPCW-1:0] stk_d [STKD];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            act_q, act_d;
  logic            err_q, err_d;
`ifdef MICRO_BREAK_EN
  logic            brk_q, brk_d;
`endif

  logic [UPCW-1:0] upc_inc;
  logic [UPCW-1:0] adr_u;
  logic [IDXW-1:0] top_idx;
  logic [15:0]     cond_eff;
  logic            cond0_unused;

  assign upc_inc      = upc_q + UPCW'(1);
  assign adr_u        = UPCW'(adr_q);
  assign top_idx      = sp_q[IDXW-1:0] - IDXW'(1);
  // COND[0] is the "always" condition so CSEL=0 turns CJMP into JMP.
  assign cond_eff     = {COND[15:1], 1'b1};
  assign cond0_unused = COND[0];

  always_comb begin
    phase_d = phase_q;
    upc_d   = upc_q;
    sq_d    = sq_q;
    csel_d  = csel_q;
    adr_d   = adr_q;
    stk_d   = stk_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    err_d   = err_q;
`ifdef MICRO_BREAK_EN
    brk_d   = brk_q;
    if (brk_q && UCONT) brk_d = 1'b0;
`endif

    unique case (phase_q)
`ifdef MICRO_BREAK_EN
      P0:      phase_d = (brk_q && !UCONT) ? P0 : P1;
`else
      P0:      phase_d = P1;
`endif
      P1:      phase_d = P2;
      P2:      phase_d = WAIT ? P2 : P3;
      P3:      phase_d = P4;
      P4:      phase_d = P0;
      default: phase_d = P0;
    endcase

    if (phase_q == P4) begin
      upc_d = upc_inc;
      act_d = 1'b0;
      case (sq_q)
        SQ_CONT: upc_d = upc_inc;
        SQ_JMP:  upc_d = adr_u;
        SQ_CJMP: if (cond_eff[csel_q]) upc_d = adr_u;
        SQ_CALL: begin
          upc_d = adr_u;
          if (sp_q == SPW'(STKD)) begin
            // Full stack: slide everything down, losing the oldest return address.
            for (int i = 0; i < STKD - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[STKD-1] = upc_inc;
            err_d         = 1'b1;
          end else begin
            stk_d[sp_q[IDXW-1:0]] = upc_inc;
            sp_d                  = sp_q + SPW'(1);
          end
        end
        SQ_RET: begin
          if (sp_q == '0) begin
            upc_d = '0;
            err_d = 1'b1;
          end else begin
            upc_d = stk_q[top_idx];
            sp_d  = sp_q - SPW'(1);
          end
        end
        SQ_DISP:  upc_d = UPCW'({adr_q[11:6], IRDISP});
        SQ_LDCNT: cnt_d = adr_q[CNTW-1:0];
        SQ_LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
            upc_d = adr_u;
            act_d = 1'b1;
          end
        end
      endcase

      sq_d   = sq_e'(ROM18_0[18:16]);
      csel_d = ROM18_0[15:12];
      adr_d  = ROM18_0[11:0];
`ifdef MICRO_BREAK_EN
      if (BRKENA && (upc_d == BRKADR)) brk_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!MCL_n) begin
      phase_q <= P0;
      upc_q   <= '0;
      sq_q    <= SQ_CONT;
      csel_q  <= '0;
      adr_q   <= '0;
      for (int i = 0; i < STKD; i++) stk_q[i] <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MICRO_BREAK_EN
      brk_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      upc_q   <= upc_d;
      sq_q    <= sq_d;
      csel_q  <= csel_d;
      adr_q   <= adr_d;
      stk_q   <= stk_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      err_q   <= err_d;
`ifdef MICRO_BREAK_EN
      brk_q   <= brk_d;
`endif
    end
  end

  assign T1      = (phase_q == P0);
  assign T3      = (phase_q == P2);
  assign T5      = (phase_q == P4);
  assign MIRKL   = (phase_q == P4);
  assign UPC     = upc_q;
  assign ACTLOOP = act_q;
  assign STKERR  = err_q;
`ifdef MICRO_BREAK_EN
  assign UBRK    = brk_q;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, mid-loop reset sequence, then random microcode against a queue-based model.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        MCL_n;
  logic [18:0] ROM18_0;
  logic [15:0] COND;
  logic [5:0]  IRDISP;
  logic        WAIT;
  logic [11:0] UPC;
  logic        MIRKL, T1, T3, T5, ACTLOOP, STKERR;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk(clk), .MCL_n(MCL_n), .ROM18_0(ROM18_0), .COND(COND), .IRDISP(IRDISP),
    .WAIT(WAIT), .UPC(UPC), .MIRKL(MIRKL), .T1(T1), .T3(T3), .T5(T5),
    .ACTLOOP(ACTLOOP), .STKERR(STKERR)
  );

  // Reference model state: latched word fields, stack as a queue (back = top).
  int m_upc, m_sq, m_csel, m_adr, m_cnt;
  bit m_act, m_err;
  int m_stk[$];

  typedef struct {
    logic [18:0] rom;
    logic [15:0] cond;
    logic [5:0]  irdisp;
    int          nwait;
    int          exp_upc;
    bit          exp_act;
    bit          exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] mkw(input int sq, input int csel, input int adr);
    logic [2:0]  s;
    logic [3:0]  c;
    logic [11:0] a;
    s = sq[2:0];
    c = csel[3:0];
    a = adr[11:0];
    return {s, c, a};
  endfunction

  task automatic model_reset();
    m_upc = 0; m_sq = 0; m_csel = 0; m_adr = 0; m_cnt = 0;
    m_act = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_end(input logic [18:0] rom, input logic [15:0] cond, input logic [5:0] irdisp);
    int inc;
    int nxt;
    bit taken;
    inc   = (m_upc + 1) % 4096;
    nxt   = inc;
    taken = 0;
    case (m_sq)
      1: nxt = m_adr;
      2: if (m_csel == 0 || cond[m_csel]) nxt = m_adr;
      3: begin
        if (m_stk.size() == 4) begin
          void'(m_stk.pop_front());
          m_err = 1;
        end
        m_stk.push_back(inc);
        nxt = m_adr;
      end
      4: begin
        if (m_stk.size() == 0) begin
          nxt   = 0;
          m_err = 1;
        end else nxt = m_stk.pop_back();
      end
      5: nxt = (m_adr / 64) * 64 + int'(irdisp);
      6: m_cnt = m_adr % 256;
      7: if (m_cnt != 0) begin
        m_cnt--;
        nxt   = m_adr;
        taken = 1;
      end
      default: nxt = inc;
    endcase
    m_act  = taken;
    m_upc  = nxt;
    m_sq   = int'(rom[18:16]);
    m_csel = int'(rom[15:12]);
    m_adr  = int'(rom[11:0]);
  endtask

  task automatic chk_phase(input int p);
    chk("T1", T1, p == 0);
    chk("T3", T3, p == 2);
    chk("T5", T5, p == 4);
    chk("MIRKL", MIRKL, p == 4);
    chk("UPC_hold", UPC, m_upc);
    chk("ACTLOOP_hold", ACTLOOP, m_act);
    chk("STKERR_hold", STKERR, m_err);
  endtask

  // Runs one full cycle starting at a P0 negedge; ends at the next P0 negedge.
  task automatic run_cycle(input logic [18:0] rom, input logic [15:0] cond,
                           input logic [5:0] irdisp, input int nwait);
    int w;
    w = nwait;
    ROM18_0 = rom; COND = cond; IRDISP = irdisp;
    chk_phase(0); @(negedge clk);
    chk_phase(1); @(negedge clk);
    chk_phase(2);
    WAIT = (w > 0);
    while (w > 0) begin
      @(negedge clk);
      w--;
      chk_phase(2);
      WAIT = (w > 0);
    end
    @(negedge clk); chk_phase(3);
    @(negedge clk); chk_phase(4);
    @(negedge clk);
    model_end(rom, cond, irdisp);
  endtask

  task automatic run_partial(input logic [18:0] rom, input int nclk);
    ROM18_0 = rom;
    for (int p = 0; p < nclk; p++) begin
      chk_phase(p);
      @(negedge clk);
    end
    chk_phase(nclk);
  endtask

  task automatic do_reset();
    MCL_n = 1'b0;
    WAIT  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_T1", T1, 1);
    chk("rst_T3", T3, 0);
    chk("rst_T5", T5, 0);
    chk("rst_MIRKL", MIRKL, 0);
    chk("rst_UPC", UPC, 0);
    chk("rst_ACTLOOP", ACTLOOP, 0);
    chk("rst_STKERR", STKERR, 0);
    MCL_n = 1'b1;
  endtask

  task automatic addv(input logic [18:0] rom, input logic [15:0] cond, input logic [5:0] ird,
                      input int nw, input int upc, input bit act, input bit err);
    vec_t v;
    v.rom = rom; v.cond = cond; v.irdisp = ird; v.nwait = nw;
    v.exp_upc = upc; v.exp_act = act; v.exp_err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [18:0] rw;
    MCL_n = 1'b0; ROM18_0 = '0; COND = '0; IRDISP = '0; WAIT = 1'b0;

    // Free run, WAIT stretch, JMP with delay slot, CJMP, stack, DISP, counted loop, wrap.
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h001, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h002, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 3, 'h003, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h004, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h005, 0, 0);
    addv(mkw(1,0,'h100),   16'h0000, 6'h00, 0, 'h006, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h100, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h101, 0, 0);
    addv(mkw(2,3,'h040),   16'h0000, 6'h00, 0, 'h102, 0, 0);
    addv(mkw(0,0,0),       16'h0008, 6'h00, 0, 'h040, 0, 0);
    addv(mkw(2,3,'h080),   16'h0000, 6'h00, 0, 'h041, 0, 0);
    addv(mkw(0,0,0),       16'hFFF7, 6'h00, 0, 'h042, 0, 0);
    addv(mkw(2,0,'h200),   16'h0000, 6'h00, 0, 'h043, 0, 0);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h200, 0, 0);
    addv(mkw(3,0,'h300),   16'h0000, 6'h00, 0, 'h201, 0, 0);
    addv(mkw(3,0,'h310),   16'h0000, 6'h00, 0, 'h300, 0, 0);
    addv(mkw(3,0,'h320),   16'h0000, 6'h00, 0, 'h310, 0, 0);
    addv(mkw(3,0,'h330),   16'h0000, 6'h00, 0, 'h320, 0, 0);
    addv(mkw(3,0,'h340),   16'h0000, 6'h00, 0, 'h330, 0, 0);
    addv(mkw(4,0,0),       16'h0000, 6'h00, 0, 'h340, 0, 1);
    addv(mkw(4,0,0),       16'h0000, 6'h00, 0, 'h331, 0, 1);
    addv(mkw(4,0,0),       16'h0000, 6'h00, 0, 'h321, 0, 1);
    addv(mkw(4,0,0),       16'h0000, 6'h00, 0, 'h311, 0, 1);
    addv(mkw(4,0,0),       16'h0000, 6'h00, 0, 'h301, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h000, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h001, 0, 1);
    addv(mkw(5,0,'hAC0),   16'h0000, 6'h00, 0, 'h002, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h15, 0, 'hAD5, 0, 1);
    addv(mkw(6,0,'h002),   16'h0000, 6'h00, 0, 'hAD6, 0, 1);
    addv(mkw(7,0,'h020),   16'h0000, 6'h00, 0, 'hAD7, 0, 1);
    addv(mkw(7,0,'h020),   16'h0000, 6'h00, 0, 'h020, 1, 1);
    addv(mkw(7,0,'h020),   16'h0000, 6'h00, 0, 'h020, 1, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h021, 0, 1);
    addv(mkw(7,0,'h050),   16'h0000, 6'h00, 0, 'h022, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h023, 0, 1);
    addv(mkw(1,0,'hFFE),   16'h0000, 6'h00, 0, 'h024, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'hFFE, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'hFFF, 0, 1);
    addv(mkw(0,0,0),       16'h0000, 6'h00, 0, 'h000, 0, 1);

    do_reset();

    foreach (vecs[i]) begin
      run_cycle(vecs[i].rom, vecs[i].cond, vecs[i].irdisp, vecs[i].nwait);
      chk($sformatf("vec%0d_UPC", i), UPC, vecs[i].exp_upc);
      chk($sformatf("vec%0d_ACTLOOP", i), ACTLOOP, vecs[i].exp_act);
      chk($sformatf("vec%0d_STKERR", i), STKERR, vecs[i].exp_err);
    end

    // Reset landing in P4 of a cycle whose latched word is a taken LOOP.
    run_cycle(mkw(6,0,'h005), 16'h0, 6'h0, 0);
    run_cycle(mkw(7,0,'h020), 16'h0, 6'h0, 0);
    run_cycle(mkw(7,0,'h020), 16'h0, 6'h0, 0);
    run_cycle(mkw(7,0,'h020), 16'h0, 6'h0, 0);
    chk("midloop_ACTLOOP_before", ACTLOOP, 1);
    chk("midloop_UPC_before", UPC, 'h020);
    run_partial(mkw(0,0,0), 4);
    do_reset();
    run_cycle(mkw(7,0,'h070), 16'h0, 6'h0, 0);
    chk("postrst_UPC1", UPC, 'h001);
    run_cycle(mkw(0,0,0), 16'h0, 6'h0, 0);
    chk("postrst_loop_cnt0_UPC", UPC, 'h002);
    chk("postrst_loop_cnt0_ACT", ACTLOOP, 0);

    // Random microcode against the model; RETs/LOOPs biased in to exercise the stack and counter.
    for (int n = 0; n < 300; n++) begin
      int nw;
      if (n % 100 == 99) do_reset();
      rw = mkw($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) rw = mkw(6, 0, $urandom_range(0, 3));
      nw = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      run_cycle(rw, 16'($urandom), 6'($urandom), nw);
      chk("rnd_UPC", UPC, m_upc);
      chk("rnd_ACTLOOP", ACTLOOP, m_act);
      chk("rnd_STKERR", STKERR, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer and phase generator sitting directly upstream of the decoding card.
- Generates the T1..T5 cycle phases, the micro-PC (UPC) that addresses the control ROM, and MIRKL, the load strobe that clocks ROM into the MIR.
- Provides the loop-active flag ACTLOOP consumed by the decoding stage.
- Next-address logic supports continue, jump, conditional jump, call/return over a small microstack, IR dispatch and counted loops.

Parameters:
- UPCW, 12, micro-PC / ROM address width.
- STKD, 4, microstack depth, power of two, minimum 2.
- CNTW, 8, loop counter width, at most UPCW.

Ports:
- clk  in  1  system clock.
- MCL_n  in  1  master clear.
- ROM18_0  in  19  sequencing fields of the word currently addressed by UPC.
- COND  in  16  condition inputs; COND[0] is ignored and treated as constant 1.
- IRDISP  in  6  dispatch bits from the instruction register.
- WAIT  in  1  memory wait; stretches T3.
- UPC  out  UPCW  control ROM address.
- MIRKL  out  1  MIR load strobe.
- T1, T3, T5  out  1 each  one-hot cycle phases.
- ACTLOOP  out  1  loop branch taken this cycle.
- STKERR  out  1  sticky microstack over/underflow flag.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. Everything updates on posedge clk only.
- Reset values (MCL_n low at an edge):
  - Phase = T1, so T1=1 and T3=T5=0.
  - UPC=0, stack empty, loop counter 0, STKERR=0.
  - Sequence latch = CONT, so SQ=0, CSEL=0 and ADR=0.
  - MIRKL=0, ACTLOOP=0.
- Reset mid-cycle aborts the cycle: no MIRKL and no UPC update at that edge.
- Phases:
  - Internal counter P0..P4, one clk each. T1 is P0, T3 is P2, T5 is P4.
  - A cycle is 5 clocks; P4 wraps to P0.
  - WAIT high while in P2 holds P2 and keeps T3 high. WAIT is sampled only in P2.
- MIRKL is high exactly during P4. The edge ending P4 is the cycle-end edge.
- At each cycle-end edge:
  - The sequence latch loads from ROM18_0: SQ=[18:16], CSEL=[15:12], ADR=[11:0].
  - UPC loads NEXT, computed from the *previous* latch contents.
  - Result: one branch delay slot. The word fetched right after a branch word always executes.
- NEXT by SQ (inc = UPC+1 mod 2^UPCW):
  - 0 CONT: inc.
  - 1 JMP: ADR.
  - 2 CJMP: ADR if COND[CSEL] is 1, else inc. COND is sampled at the cycle-end edge.
  - 3 CALL: push inc, NEXT=ADR. If the stack is full, drop the oldest entry, push, and set STKERR.
  - 4 RET: pop to NEXT. If the stack is empty, NEXT=0 and set STKERR.
  - 5 DISP: {ADR[11:6], IRDISP}.
  - 6 LDCNT: counter = ADR[CNTW-1:0], NEXT=inc.
  - 7 LOOP: if counter is nonzero, counter decrements and NEXT=ADR; if counter is 0, NEXT=inc and the counter stays 0.
- ACTLOOP:
  - High for the whole cycle (P0..P4) following the cycle-end edge where a LOOP branch was taken.
  - Cleared at the next cycle-end edge unless that edge also takes a LOOP branch.
- STKERR clears only on reset.
- UPC wraps from all-ones to 0 without error.
- An ADR wider than UPCW is truncated to its low bits.

Optional Feature:
- Macro: MICRO_BREAK_EN.
- With the macro defined, the block adds these ports:
  - BRKADR in UPCW.
  - BRKENA in 1.
  - UCONT in 1.
  - UBRK out 1.
- Break behaviour:
  - When BRKENA=1 and the UPC loaded at a cycle-end edge equals BRKADR, the phase counter freezes in P0 and UBRK goes high.
  - While frozen, MIRKL is not issued and UPC is unchanged.
  - A one-clock UCONT pulse releases the freeze; UBRK clears and counting resumes at P1.
  - Reset clears the freeze.
- Without the macro: none of these ports exist and there is no freeze path.

Test Plan:
- Reset then free run with ROM18_0 all zero → T1/T3/T5 repeat at a 5-clock period, MIRKL on every 5th clock, UPC = 0,1,2,3.
- WAIT high for 3 clocks during T3 → that cycle lasts 8 clocks, T3 is high for 4 clocks, and MIRKL and UPC slip by 3.
- JMP 0x100 fetched at UPC=5 → UPC sequence 5,6,0x100, with the delay slot at 6 executing.
- CJMP with CSEL=3 → to 0x040 when COND[3]=1, to inc when COND[3]=0; with CSEL=0 the jump is always taken.
- Five CALLs with STKD=4, then five RETs → STKERR sets on the 5th push; the 4 RETs return in LIFO order; the 5th RET (stack empty) gives UPC=0.
- LDCNT 2 followed by LOOP to 0x020 → two taken branches with ACTLOOP high for those two cycles, then fall-through with ACTLOOP=0; reset asserted mid-loop → counter=0, ACTLOOP=0, UPC=0.
